// File: rtl/bios_loader_pkg.sv
// Shared loader definitions: FSM state encoding and HPS ioctl target ids.
package bios_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_FINISH
    } ld_state_e;

    localparam logic [7:0] IDX_BIOS   = 8'd0;
    localparam logic [7:0] IDX_OPTROM = 8'd1;
    localparam logic [7:0] IDX_FONT   = 8'd2;

endpackage

// File: rtl/bios_loader.sv
// BIOS ROM loader: writes the HPS ioctl byte stream into BIOS memory,
// sums the image, and passes CPU reads through while idle.
module bios_loader
    import bios_loader_pkg::*;
#(
    parameter int              ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hE000,
    parameter int              IMAGE_SIZE = 8192,
    parameter logic [7:0]      INDEX      = IDX_BIOS
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    output logic              ioctl_wait,
    input  logic              cpu_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_hold,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [7:0]        mem_dina,
    output logic              busy,
    output logic              done,
    output logic              cksum_ok,
    output logic [7:0]        checksum,
    output logic              overflow
);

    localparam int CNT_W = $clog2(IMAGE_SIZE) + 1;

    ld_state_e         state_q;
    logic              dl_q;
    logic              wait_q;
    logic              hold_q;
    logic              done_q;
    logic              ok_q;
    logic              ovf_q;
    logic [7:0]        sum_q;
    logic [7:0]        sum_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              start;
    logic              in_range;

    assign start    = ioctl_download & ~dl_q & (ioctl_index == INDEX);
    assign in_range = ioctl_addr < 25'(IMAGE_SIZE);
    assign sum_d    = sum_q + data_q;
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clka) begin
        dl_q <= ioctl_download;
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        ok_q    <= 1'b0;
                        ovf_q   <= 1'b0;
                        hold_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (ioctl_wr) begin
                        if (in_range) begin
                            addr_q  <= ioctl_addr[ADDR_W-1:0];
                            data_q  <= ioctl_data;
                            wait_q  <= 1'b1;
                            state_q <= ST_WRITE;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (!ioctl_download) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_WRITE: begin
                    // strobes seen here violate the handshake and are ignored
                    sum_q   <= sum_d;
                    cnt_q   <= cnt_d;
                    wait_q  <= 1'b0;
                    state_q <= ioctl_download ? ST_LOAD : ST_FINISH;
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    ok_q    <= (sum_q == 8'h00) &&
                               (cnt_q == CNT_W'(IMAGE_SIZE));
                    hold_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_ena   = 1'b0;
        mem_wea   = 1'b0;
        mem_addra = BASE_ADDR + addr_q;
        unique case (state_q)
            ST_IDLE: begin
                mem_ena   = cpu_en;
                mem_addra = cpu_addr;
            end
            ST_WRITE: begin
                mem_ena = 1'b1;
                mem_wea = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_dina   = data_q;
    assign ioctl_wait = wait_q;
    assign cpu_hold   = hold_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign cksum_ok   = ok_q;
    assign checksum   = sum_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader with a behavioural 64 KiB BIOS memory
// and a write monitor on the memory port.
module tb_bios_loader;

    logic        clka = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic        cpu_en;
    logic [15:0] cpu_addr;
    logic        cpu_hold;
    logic        mem_ena;
    logic        mem_wea;
    logic [15:0] mem_addra;
    logic [7:0]  mem_dina;
    logic        busy;
    logic        done;
    logic        cksum_ok;
    logic [7:0]  checksum;
    logic        overflow;

    logic [7:0]  mem [0:65535];
    logic [7:0]  douta;
    int          wr_cnt = 0;
    int          oob_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clka = ~clka;

    bios_loader dut (
        .clka           (clka),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .cpu_en         (cpu_en),
        .cpu_addr       (cpu_addr),
        .cpu_hold       (cpu_hold),
        .mem_ena        (mem_ena),
        .mem_wea        (mem_wea),
        .mem_addra      (mem_addra),
        .mem_dina       (mem_dina),
        .busy           (busy),
        .done           (done),
        .cksum_ok       (cksum_ok),
        .checksum       (checksum),
        .overflow       (overflow)
    );

    always @(posedge clka) begin
        if (mem_ena) begin
            if (mem_wea) begin
                mem[mem_addra] <= mem_dina;
                wr_cnt = wr_cnt + 1;
                if (mem_addra < 16'hE000)
                    oob_cnt = oob_cnt + 1;
            end
            douta <= mem[mem_addra];
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // pattern 0 sums to 0 mod 256 over 8192 bytes
    function automatic logic [7:0] bval(input int pat, input int i);
        int v;
        v = (pat == 0) ? (7 * i + 3) : (i ^ 32'h5A);
        return v[7:0];
    endfunction

    task automatic send_byte(input int a, input logic [7:0] d);
        ioctl_addr = 25'(a);
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        tick();
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic load(input int n, input int pat, input logic [7:0] adj);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bval(pat, i);
            if (i == n - 1)
                b = b + adj;
            send_byte(i, b);
        end
    endtask

    initial begin
        int w0;
        logic [7:0] s;
        logic [7:0] e;

        for (int i = 0; i < 65536; i++)
            mem[i] = 8'hA5;
        douta          = 8'h00;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        cpu_en         = 1'b0;
        cpu_addr       = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_done", done, 0);
        check("rst_ok", cksum_ok, 0);
        check("rst_ovf", overflow, 0);
        check("rst_sum", checksum, 0);
        check("rst_wait", ioctl_wait, 0);

        // 1: full good image
        w0 = wr_cnt;
        start_dl(8'd0);
        check("t1_hold", cpu_hold, 1);
        check("t1_busy", busy, 1);
        ioctl_addr = 25'd0;
        ioctl_data = bval(0, 0);
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        check("t1_wait", ioctl_wait, 1);
        check("t1_wea", mem_wea, 1);
        check("t1_addr0", mem_addra, 16'hE000);
        tick();
        check("t1_wait_clr", ioctl_wait, 0);
        for (int i = 1; i < 8192; i++)
            send_byte(i, bval(0, i));
        end_dl();
        check("t1_writes", wr_cnt - w0, 8192);
        check("t1_oob", oob_cnt, 0);
        check("t1_done", done, 1);
        check("t1_ok", cksum_ok, 1);
        check("t1_sum", checksum, 8'h00);
        check("t1_hold_end", cpu_hold, 0);
        check("t1_busy_end", busy, 0);
        check("t1_mem_e000", mem[16'hE000], 8'h03);
        check("t1_mem_ffff", mem[16'hFFFF], bval(0, 8191));

        // 2: last byte +1
        start_dl(8'd0);
        load(8192, 0, 8'd1);
        end_dl();
        check("t2_done", done, 1);
        check("t2_ok", cksum_ok, 0);
        check("t2_sum", checksum, 8'h01);
        check("t2_mem_ffff", mem[16'hFFFF], bval(0, 8191) + 8'd1);

        // 3: short download of 100 bytes
        w0 = wr_cnt;
        start_dl(8'd0);
        check("t3_done_clr", done, 0);
        load(100, 1, 8'd0);
        end_dl();
        s = 8'h00;
        for (int i = 0; i < 100; i++)
            s = s + bval(1, i);
        check("t3_writes", wr_cnt - w0, 100);
        check("t3_done", done, 1);
        check("t3_ok", cksum_ok, 0);
        check("t3_sum", checksum, s);
        check("t3_mem_e000", mem[16'hE000], 8'h5A);
        check("t3_mem_e063", mem[16'hE063], 8'h39);
        check("t3_mem_e064", mem[16'hE064], 8'hBF);

        // 4: out-of-range byte dropped
        w0 = wr_cnt;
        start_dl(8'd0);
        send_byte(8192, 8'h77);
        check("t4_busy", busy, 1);
        end_dl();
        check("t4_writes", wr_cnt - w0, 0);
        check("t4_ovf", overflow, 1);
        check("t4_done", done, 1);
        check("t4_ok", cksum_ok, 0);
        check("t4_sum", checksum, 8'h00);
        check("t4_oob", oob_cnt, 0);

        // 5: foreign index, CPU pass-through stays live
        w0 = wr_cnt;
        cpu_en   = 1'b1;
        cpu_addr = 16'hFFF0;
        start_dl(8'd1);
        send_byte(5, 8'h11);
        check("t5_ena", mem_ena, 1);
        check("t5_wea", mem_wea, 0);
        check("t5_addr", mem_addra, 16'hFFF0);
        check("t5_hold", cpu_hold, 0);
        check("t5_busy", busy, 0);
        e = bval(0, 8176);
        check("t5_douta", douta, e);
        end_dl();
        check("t5_writes", wr_cnt - w0, 0);
        check("t5_ovf_kept", overflow, 1);
        cpu_en = 1'b0;

        // 6: reset mid-download, then a full good image
        start_dl(8'd0);
        load(10, 1, 8'd0);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_hold", cpu_hold, 0);
        check("t6_done", done, 0);
        start_dl(8'd0);
        load(8192, 0, 8'd0);
        end_dl();
        check("t6_done2", done, 1);
        check("t6_ok", cksum_ok, 1);
        check("t6_ovf", overflow, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
